grey_counter: RTL and testbench
===============================

# grey_counter

Parametrised registered Gray-code counter, the sequential successor to the combinational 3-bit binary-to-Grey encoder. It holds a WIDTH-bit binary count and presents it in both binary and Grey form, with clock enable, up/down direction, synchronous load and a wrap pulse. It is the building block for multi-bit values that cross clock domains, such as FIFO read and write pointers, and for glitch-free position and step counters.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; advance one step per cycle while high.
- up  in  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  binary value to load.
- bin_out  out  WIDTH  registered binary count.
- grey_out  out  WIDTH  registered Grey code of bin_out.
- wrap  out  1  one-cycle pulse on a wrap (or saturation) event.

## Operation
- Single state register: binary count bcnt.
- grey_out = bcnt ^ (bcnt >> 1), taken from the next-state value and registered, so it is never combinational from bcnt.
- Per-edge priority: rst > load > en > hold.
  - rst: bcnt=0, grey_out=0, wrap=0.
  - load: bcnt=load_val, grey_out=grey(load_val), wrap=0. en is ignored that cycle.
  - en & up: bcnt+1, modulo 2^WIDTH.
  - en & !up: bcnt-1, modulo 2^WIDTH.
  - Otherwise: all registers hold and wrap=0.
- wrap is registered. It is 1 only in the cycle after an enabled step from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
- Every enabled step changes exactly one bit of grey_out, including across a wrap. A load may change any number of bits.
- Direction may change on any cycle with no penalty.
- Arithmetic is unsigned and truncated to WIDTH bits. There is no carry output.

## Timing
- Latency: one cycle from a sampled en/load to updated bin_out, grey_out and wrap.
- bin_out and grey_out always update on the same edge and always match.
- Reset values: bin_out=0, grey_out=0, wrap=0. Reset is held while rst=1. The first step is taken on the first edge with rst=0 and en=1.
- rst asserted mid-count clears everything on that edge. Any in-flight wrap pulse is dropped.
- load and en high together: the load wins and no step is taken.
- en=1 for N consecutive cycles advances the count by exactly N (mod 2^WIDTH), with no bubbles.

## Configuration
- GREY_COUNTER_SAT_EN
  - Undefined (default): modulo wrap as described above.
  - Defined: the counter saturates. An up-step at 2^WIDTH-1 or a down-step at 0 leaves bcnt unchanged, and wrap pulses for one cycle to flag saturation. A step away from the limit proceeds normally. Load and reset behaviour is unchanged.

## Structure
- Shared package grey_pkg holds:
  - GREY_DEFAULT_WIDTH = 4.
  - Direction constants DIR_UP = 1 and DIR_DOWN = 0.
  - Reset constant for the count (all zeros).
- One sub-module, grey_enc: a purely combinational binary-to-Grey encoder parameterised by WIDTH. It is instantiated once on the next-state binary value and reused by the pointer logic in the async FIFO.
- The counter next-state logic, the wrap/saturation detect and the output registers live in grey_counter itself.

## Test plan
All scenarios use WIDTH=3 unless stated.
- Reset, then en=1 and up=1 for 9 cycles -> grey_out 000, 001, 011, 010, 110, 111, 101, 100, 000. wrap=1 only in the cycle grey_out returns to 000.
- Load load_val=101 -> next cycle bin_out=101, grey_out=111, wrap=0. Then en=1, up=0 for one cycle -> bin_out=100, grey_out=110.
- From reset, en=1 and up=0 -> bin_out=111, grey_out=100, wrap=1 for one cycle.
- Count up to bin_out=110, assert rst together with en -> next cycle bin_out=000, grey_out=000, wrap=0.
- WIDTH=8, random en, up and load for 10k cycles -> grey_out always equals bin_out ^ (bin_out>>1), and the Hamming distance between consecutive grey_out values is 1 on every enabled non-load step.
- GREY_COUNTER_SAT_EN defined, load 111, en=1, up=1 -> bin_out stays 111 and wrap=1. Then up=0 -> bin_out=110 and wrap=0.

Source files
------------

// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared constants for the Grey-code counter family
//
// Holds the default counter width, the direction encodings for the up input
// and the all-zeros reset value of the binary count.
package grey_pkg;

    localparam int GREY_DEFAULT_WIDTH = 4;

    // Encodings of the up input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Reset value of the binary count. It is sized for the widest legal
    // counter; each instance takes its low WIDTH bits.
    localparam logic [31:0] GREY_CNT_RST = '0;

endpackage

// File: rtl/grey_counter_if.sv
// rtl/grey_counter_if.sv - control and count signals of grey_counter
//
// Signals:
//   en       count enable, one step per cycle while high
//   up       direction (DIR_UP / DIR_DOWN), only looked at while en=1
//   load     synchronous load strobe, takes priority over en
//   load_val binary value to load
//   bin_out  registered binary count
//   grey_out registered Grey code of bin_out
//   wrap     one-cycle pulse after a wrap or saturation step
// Modports: master drives the controls, slave is the counter.
interface grey_counter_if #(
    parameter int WIDTH = grey_pkg::GREY_DEFAULT_WIDTH
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] grey_out;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  bin_out, grey_out, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output bin_out, grey_out, wrap
    );
endinterface

// File: rtl/grey_enc.sv
// rtl/grey_enc.sv - combinational binary-to-Grey encoder
//
// Ports:
//   bin   in  WIDTH  binary value
//   grey  out WIDTH  Grey code of bin
module grey_enc #(
    parameter int WIDTH = grey_pkg::GREY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] grey
);

    assign grey = bin ^ (bin >> 1);

endmodule

// File: rtl/grey_counter.sv
// rtl/grey_counter.sv - registered up/down counter with binary and Grey outputs
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous, active-high reset
//   cnt   grey_counter_if.slave (en, up, load, load_val, bin_out, grey_out, wrap)
// Priority on each edge: rst > load > en > hold.
// Build option GREY_COUNTER_SAT_EN: when defined, steps past either end of the
// range saturate instead of wrapping; wrap then flags the saturated step.
module grey_counter
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    grey_counter_if.slave cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_RST = GREY_CNT_RST[WIDTH-1:0];

    logic [WIDTH-1:0] bcnt;
    logic [WIDTH-1:0] bcnt_nxt;
    logic [WIDTH-1:0] grey_q;
    logic [WIDTH-1:0] grey_nxt;
    logic             wrap_q;
    logic             wrap_nxt;

    always_comb begin
        bcnt_nxt = bcnt;
        wrap_nxt = 1'b0;
        if (cnt.load) begin
            bcnt_nxt = cnt.load_val;
        end else if (cnt.en) begin
            if (cnt.up == DIR_UP) begin
                if (bcnt == CNT_MAX) begin
                    wrap_nxt = 1'b1;
`ifdef GREY_COUNTER_SAT_EN
                    bcnt_nxt = bcnt;
`else
                    bcnt_nxt = CNT_RST;
`endif
                end else begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end else begin
                if (bcnt == CNT_RST) begin
                    wrap_nxt = 1'b1;
`ifdef GREY_COUNTER_SAT_EN
                    bcnt_nxt = bcnt;
`else
                    bcnt_nxt = CNT_MAX;
`endif
                end else begin
                    bcnt_nxt = bcnt - 1'b1;
                end
            end
        end
    end

    // Encode the next-state count so grey_out is a plain register, keeping
    // it glitch-free for consumers in another clock domain.
    grey_enc #(.WIDTH(WIDTH)) u_enc (
        .bin  (bcnt_nxt),
        .grey (grey_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt   <= CNT_RST;
            grey_q <= CNT_RST;
            wrap_q <= 1'b0;
        end else begin
            bcnt   <= bcnt_nxt;
            grey_q <= grey_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign cnt.bin_out  = bcnt;
    assign cnt.grey_out = grey_q;
    assign cnt.wrap     = wrap_q;

endmodule

// File: tb/tb_grey_counter.sv
// tb/tb_grey_counter.sv - self-checking bench for grey_counter (WIDTH 3 and 8)
module tb_grey_counter;
    import grey_pkg::*;

`ifdef GREY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst3;
    logic rst8;

    grey_counter_if #(.WIDTH(3)) if3 ();
    grey_counter_if #(.WIDTH(8)) if8 ();

    grey_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst3), .cnt(if3.slave));
    grey_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .cnt(if8.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the count as a plain integer plus the pending wrap flag.
    int m3_cnt = 0;
    int m8_cnt = 0;
    bit m3_wrap = 1'b0;
    bit m8_wrap = 1'b0;

    task automatic model_next(input int w, input bit r, input bit ld, input int lv,
                              input bit en, input bit up, input int cnt,
                              output int cnt_n, output bit wrap_n);
        int modulus;
        modulus = 1 << w;
        cnt_n  = cnt;
        wrap_n = 1'b0;
        if (r) begin
            cnt_n = 0;
        end else if (ld) begin
            cnt_n = lv;
        end else if (en) begin
            int raw;
            raw = up ? cnt + 1 : cnt - 1;
            if (raw < 0 || raw >= modulus) begin
                wrap_n = 1'b1;
                cnt_n  = SAT ? cnt : (raw + modulus) % modulus;
            end else begin
                cnt_n = raw;
            end
        end
    endtask

    // Advance one clock: both models see the inputs applied at the edge,
    // outputs are sampled 1ns after the edge.
    task automatic tick();
        int c3, c8;
        bit w3, w8;
        model_next(3, rst3, if3.load, int'(if3.load_val), if3.en, if3.up, m3_cnt, c3, w3);
        model_next(8, rst8, if8.load, int'(if8.load_val), if8.en, if8.up, m8_cnt, c8, w8);
        @(posedge clk);
        m3_cnt = c3; m3_wrap = w3;
        m8_cnt = c8; m8_wrap = w8;
        #1;
    endtask

    task automatic idle3();
        if3.en = 1'b0; if3.up = 1'b0; if3.load = 1'b0; if3.load_val = '0;
    endtask

    task automatic test_reset();
        idle3();
        if8.en = 1'b0; if8.up = 1'b0; if8.load = 1'b0; if8.load_val = '0;
        rst3 = 1'b1; rst8 = 1'b1;
        if3.en = 1'b1; if3.up = 1'b1;
        tick(); tick();
        checks++; if (if3.bin_out !== 3'b000) begin errors++; $display("FAIL reset_bin: got %b expected 000", if3.bin_out); end
        checks++; if (if3.grey_out !== 3'b000) begin errors++; $display("FAIL reset_grey: got %b expected 000", if3.grey_out); end
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", if3.wrap); end
        rst3 = 1'b0;
        idle3();
    endtask

    task automatic test_count_up();
        logic [2:0] exp_g [9];
        exp_g[0] = 3'b000; exp_g[1] = 3'b001; exp_g[2] = 3'b011; exp_g[3] = 3'b010;
        exp_g[4] = 3'b110; exp_g[5] = 3'b111; exp_g[6] = 3'b101; exp_g[7] = 3'b100;
        exp_g[8] = SAT ? 3'b100 : 3'b000;
        rst3 = 1'b1; tick(); rst3 = 1'b0;
        if3.en = 1'b1; if3.up = DIR_UP;
        checks++; if (if3.grey_out !== exp_g[0]) begin errors++; $display("FAIL count_up_grey[0]: got %b expected %b", if3.grey_out, exp_g[0]); end
        for (int i = 1; i < 9; i++) begin
            tick();
            checks++; if (if3.grey_out !== exp_g[i]) begin errors++; $display("FAIL count_up_grey[%0d]: got %b expected %b", i, if3.grey_out, exp_g[i]); end
            checks++; if (if3.wrap !== (i == 8)) begin errors++; $display("FAIL count_up_wrap[%0d]: got %b expected %b", i, if3.wrap, (i == 8)); end
        end
        idle3();
        tick();
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL count_up_wrap_clear: got %b expected 0", if3.wrap); end
    endtask

    task automatic test_load();
        if3.load = 1'b1; if3.load_val = 3'b101;
        tick();
        checks++; if (if3.bin_out !== 3'b101) begin errors++; $display("FAIL load_bin: got %b expected 101", if3.bin_out); end
        checks++; if (if3.grey_out !== 3'b111) begin errors++; $display("FAIL load_grey: got %b expected 111", if3.grey_out); end
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %b expected 0", if3.wrap); end
        idle3(); if3.en = 1'b1; if3.up = DIR_DOWN;
        tick();
        checks++; if (if3.bin_out !== 3'b100) begin errors++; $display("FAIL load_down_bin: got %b expected 100", if3.bin_out); end
        checks++; if (if3.grey_out !== 3'b110) begin errors++; $display("FAIL load_down_grey: got %b expected 110", if3.grey_out); end
        idle3();
    endtask

    task automatic test_down_from_reset();
        rst3 = 1'b1; tick(); rst3 = 1'b0;
        if3.en = 1'b1; if3.up = DIR_DOWN;
        tick();
        checks++; if (if3.bin_out !== (SAT ? 3'b000 : 3'b111)) begin errors++; $display("FAIL down_bin: got %b expected %b", if3.bin_out, (SAT ? 3'b000 : 3'b111)); end
        checks++; if (if3.grey_out !== (SAT ? 3'b000 : 3'b100)) begin errors++; $display("FAIL down_grey: got %b expected %b", if3.grey_out, (SAT ? 3'b000 : 3'b100)); end
        checks++; if (if3.wrap !== 1'b1) begin errors++; $display("FAIL down_wrap: got %b expected 1", if3.wrap); end
        idle3();
        tick();
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_pulse: got %b expected 0", if3.wrap); end
    endtask

    task automatic test_reset_mid();
        rst3 = 1'b1; tick(); rst3 = 1'b0;
        if3.en = 1'b1; if3.up = DIR_UP;
        repeat (6) tick();
        checks++; if (if3.bin_out !== 3'b110) begin errors++; $display("FAIL mid_pre_bin: got %b expected 110", if3.bin_out); end
        rst3 = 1'b1;
        tick();
        checks++; if (if3.bin_out !== 3'b000) begin errors++; $display("FAIL mid_rst_bin: got %b expected 000", if3.bin_out); end
        checks++; if (if3.grey_out !== 3'b000) begin errors++; $display("FAIL mid_rst_grey: got %b expected 000", if3.grey_out); end
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_wrap: got %b expected 0", if3.wrap); end
        // Reset on the very edge that would otherwise wrap drops the pulse.
        rst3 = 1'b0; if3.load = 1'b1; if3.load_val = 3'b111; if3.en = 1'b0;
        tick();
        if3.load = 1'b0; if3.en = 1'b1; if3.up = DIR_UP; rst3 = 1'b1;
        tick();
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_drop_wrap: got %b expected 0", if3.wrap); end
        rst3 = 1'b0;
        idle3();
    endtask

    task automatic test_back_to_back();
        if3.load = 1'b1; if3.load_val = 3'b010; if3.en = 1'b1; if3.up = DIR_UP;
        tick();
        checks++; if (if3.bin_out !== 3'b010) begin errors++; $display("FAIL load_en_bin: got %b expected 010", if3.bin_out); end
        checks++; if (if3.grey_out !== 3'b011) begin errors++; $display("FAIL load_en_grey: got %b expected 011", if3.grey_out); end
        if3.load_val = 3'b111;
        tick(); tick();
        checks++; if (if3.bin_out !== 3'b111) begin errors++; $display("FAIL load_en_top_bin: got %b expected 111", if3.bin_out); end
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL load_en_top_wrap: got %b expected 0", if3.wrap); end
        idle3();
    endtask

`ifdef GREY_COUNTER_SAT_EN
    task automatic test_saturate();
        if3.load = 1'b1; if3.load_val = 3'b111;
        tick();
        if3.load = 1'b0; if3.en = 1'b1; if3.up = DIR_UP;
        tick();
        checks++; if (if3.bin_out !== 3'b111) begin errors++; $display("FAIL sat_bin: got %b expected 111", if3.bin_out); end
        checks++; if (if3.wrap !== 1'b1) begin errors++; $display("FAIL sat_wrap: got %b expected 1", if3.wrap); end
        if3.up = DIR_DOWN;
        tick();
        checks++; if (if3.bin_out !== 3'b110) begin errors++; $display("FAIL sat_down_bin: got %b expected 110", if3.bin_out); end
        checks++; if (if3.wrap !== 1'b0) begin errors++; $display("FAIL sat_down_wrap: got %b expected 0", if3.wrap); end
        idle3();
    endtask
`endif

    task automatic test_random();
        int prev3, prev8;
        logic [2:0] pg3;
        logic [7:0] pg8;
        bit step3, step8;
        rst8 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            rst3 = ($urandom_range(0, 199) == 0);
            rst8 = ($urandom_range(0, 199) == 0);
            if3.load = ($urandom_range(0, 15) == 0);
            if8.load = ($urandom_range(0, 15) == 0);
            if3.en = ($urandom_range(0, 3) != 0);
            if8.en = ($urandom_range(0, 3) != 0);
            if3.up = 1'($urandom);
            if8.up = 1'($urandom);
            if3.load_val = 3'($urandom);
            if8.load_val = 8'($urandom);
            step3 = !rst3 && !if3.load && if3.en;
            step8 = !rst8 && !if8.load && if8.en;
            prev3 = m3_cnt; prev8 = m8_cnt;
            pg3 = if3.grey_out; pg8 = if8.grey_out;
            tick();
            checks++; if (if3.bin_out !== 3'(m3_cnt)) begin errors++; $display("FAIL rnd3_bin@%0d: got %0d expected %0d", n, if3.bin_out, m3_cnt); end
            checks++; if (if3.grey_out !== 3'(m3_cnt ^ (m3_cnt >> 1))) begin errors++; $display("FAIL rnd3_grey@%0d: got %b expected %b", n, if3.grey_out, 3'(m3_cnt ^ (m3_cnt >> 1))); end
            checks++; if (if3.wrap !== m3_wrap) begin errors++; $display("FAIL rnd3_wrap@%0d: got %b expected %b", n, if3.wrap, m3_wrap); end
            checks++; if (if8.bin_out !== 8'(m8_cnt)) begin errors++; $display("FAIL rnd8_bin@%0d: got %0d expected %0d", n, if8.bin_out, m8_cnt); end
            checks++; if (if8.grey_out !== 8'(m8_cnt ^ (m8_cnt >> 1))) begin errors++; $display("FAIL rnd8_grey@%0d: got %b expected %b", n, if8.grey_out, 8'(m8_cnt ^ (m8_cnt >> 1))); end
            checks++; if (if8.wrap !== m8_wrap) begin errors++; $display("FAIL rnd8_wrap@%0d: got %b expected %b", n, if8.wrap, m8_wrap); end
            if (step3 && prev3 != m3_cnt) begin
                checks++; if ($countones(if3.grey_out ^ pg3) != 1) begin errors++; $display("FAIL rnd3_hamming@%0d: got %0d expected 1", n, $countones(if3.grey_out ^ pg3)); end
            end
            if (step8 && prev8 != m8_cnt) begin
                checks++; if ($countones(if8.grey_out ^ pg8) != 1) begin errors++; $display("FAIL rnd8_hamming@%0d: got %0d expected 1", n, $countones(if8.grey_out ^ pg8)); end
            end
        end
        rst3 = 1'b0; rst8 = 1'b0;
        idle3();
    endtask

    initial begin
        rst3 = 1'b1; rst8 = 1'b1;
        test_reset();
        test_count_up();
        test_load();
        test_down_from_reset();
        test_reset_mid();
        test_back_to_back();
`ifdef GREY_COUNTER_SAT_EN
        test_saturate();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
